// File: rtl/gaussian_window_feeder.sv
// Row-ring window feeder for the 5x5 gaussian core: buffers 6 image rows and replays
// each pixel's 5x5 neighbourhood as 25 serial taps. Border mode: GAUSS_FEED_REPLICATE_EN.
module gaussian_window_feeder #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_pixel,
  output logic          in_ready,
  output logic [DW-1:0] win_pixel,
  output logic [4:0]    win_id,
  output logic          win_valid,
  output logic          win_done,
  output logic          win_clr,
  output logic          frame_done
);

  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = $clog2(IMG_H + 1);
  localparam int DEPTH = 6 * IMG_W;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TAP       = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_CLEAR     = 3'd3;
  localparam logic [2:0] S_FRAME_END = 3'd4;

  logic [2:0]    state;
  logic          run;
  logic [CW-1:0] wr_col;
  logic [RW-1:0] wr_row;
  logic [2:0]    wr_slot;
  logic [CW-1:0] cx, next_cx;
  logic [RW-1:0] cy, next_cy;
  logic [4:0]    tap_id;
  logic [2:0]    tap_dx, tap_dy;
  logic          accept, last_centre, oob;
  logic [AW-1:0] rd_addr, wr_addr;
  int            tx, ty;

  logic [DW-1:0] ring [DEPTH];

  // Centre row cy needs rows up to cy+2 (clamped to the last row) fully written.
  function automatic logic centre_ready(input logic [RW-1:0] row, input logic [RW-1:0] written);
    int need;
    need = int'(row) + 2;
    if (need > IMG_H - 1) need = IMG_H - 1;
    return int'(written) > need;
  endfunction

  // Ingest may run up to row cy+3, whose slot never aliases the rows being tapped.
  assign in_ready = run && (state != S_FRAME_END) && !frame_done &&
                    (int'(wr_row) < IMG_H) && (int'(wr_row) <= int'(cy) + 3);
  assign accept      = in_valid && in_ready;
  assign last_centre = (cx == CW'(IMG_W - 1)) && (cy == RW'(IMG_H - 1));
  assign wr_addr     = AW'(int'(wr_slot) * IMG_W + int'(wr_col));

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    next_cx = cx + CW'(1);
    next_cy = cy;
    if (cx == CW'(IMG_W - 1)) begin
      next_cx = '0;
      next_cy = cy + RW'(1);
    end
  end

  always_comb begin
    tx  = int'(cx) + int'(tap_dx) - 2;
    ty  = int'(cy) + int'(tap_dy) - 2;
    oob = 1'b0;
`ifdef GAUSS_FEED_REPLICATE_EN
    if (tx < 0)      tx = 0;
    if (tx >= IMG_W) tx = IMG_W - 1;
    if (ty < 0)      ty = 0;
    if (ty >= IMG_H) ty = IMG_H - 1;
`else
    oob = (tx < 0) || (tx >= IMG_W) || (ty < 0) || (ty >= IMG_H);
    if (oob) begin
      tx = 0;
      ty = 0;
    end
`endif
    rd_addr = AW'((ty % 6) * IMG_W + tx);
  end

  // NOTE: the row ring has no reset; its contents are don't-care until rows are written.
  always_ff @(posedge clk) begin
    if (accept) ring[wr_addr] <= in_pixel;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_col  <= '0;
      wr_row  <= '0;
      wr_slot <= '0;
    end else if (state == S_FRAME_END) begin
      wr_col  <= '0;
      wr_row  <= '0;
      wr_slot <= '0;
    end else if (accept) begin
      if (wr_col == CW'(IMG_W - 1)) begin
        wr_col  <= '0;
        wr_row  <= wr_row + RW'(1);
        wr_slot <= (wr_slot == 3'd5) ? 3'd0 : wr_slot + 3'd1;
      end else begin
        wr_col <= wr_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cx     <= '0;
      cy     <= '0;
      tap_id <= '0;
      tap_dx <= '0;
      tap_dy <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (centre_ready(cy, wr_row)) state <= S_TAP;
        end
        S_TAP: begin
          if (tap_id == 5'd24) begin
            state <= S_SETTLE;
          end else begin
            tap_id <= tap_id + 5'd1;
            if (tap_dx == 3'd4) begin
              tap_dx <= 3'd0;
              tap_dy <= tap_dy + 3'd1;
            end else begin
              tap_dx <= tap_dx + 3'd1;
            end
          end
        end
        S_SETTLE: begin
          state  <= S_CLEAR;
          tap_id <= '0;
          tap_dx <= '0;
          tap_dy <= '0;
        end
        S_CLEAR: begin
          if (last_centre) begin
            state <= S_FRAME_END;
          end else begin
            cx    <= next_cx;
            cy    <= next_cy;
            state <= centre_ready(next_cy, wr_row) ? S_TAP : S_IDLE;
          end
        end
        S_FRAME_END: begin
          state <= S_IDLE;
          cx    <= '0;
          cy    <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs trail the state by one cycle, matching the one-cycle ring read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_pixel  <= '0;
      win_id     <= '0;
      win_valid  <= 1'b0;
      win_done   <= 1'b0;
      win_clr    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_pixel  <= ((state == S_TAP) && !oob) ? ring[rd_addr] : '0;
      win_id     <= (state == S_TAP) ? tap_id : 5'd0;
      win_valid  <= (state == S_TAP);
      win_done   <= (state == S_SETTLE);
      win_clr    <= (state == S_CLEAR);
      frame_done <= (state == S_FRAME_END);
    end
  end

endmodule

// File: tb/tb_gaussian_window_feeder.sv
// Scoreboard bench for gaussian_window_feeder on an 8x6 ramp image (pixel = 16*row+col).
module tb_gaussian_window_feeder;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_pixel = '0;
  logic        in_ready;
  logic [15:0] win_pixel;
  logic [4:0]  win_id;
  logic        win_valid, win_done, win_clr, frame_done;

  gaussian_window_feeder #(.IMG_W(W), .IMG_H(H), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_ready(in_ready), .win_pixel(win_pixel), .win_id(win_id),
    .win_valid(win_valid), .win_done(win_done), .win_clr(win_clr),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  id;
    logic [15:0] pix;
  } tap_t;

  tap_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int   windows_done = 0, tap_run = 0, frames_seen = 0, accepted = 0, hot = 0;
  logic prev_valid = 0, prev_done = 0, prev_clr = 0, prev_fd = 0, prev_ready = 0;
  logic dropped = 0, recovered = 0;
  time  t_row2 = 0, last_rise = 0;
  tap_t e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_tap(input int cx, input int cy, input int id);
    int x, y;
    x = cx + id % 5 - 2;
    y = cy + id / 5 - 2;
`ifdef GAUSS_FEED_REPLICATE_EN
    if (x < 0) x = 0;
    if (x > W - 1) x = W - 1;
    if (y < 0) y = 0;
    if (y > H - 1) y = H - 1;
`else
    if (x < 0 || x > W - 1 || y < 0 || y > H - 1) return 16'h0000;
`endif
    return 16'(16 * y + x);
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_pix"}, win_pixel, 0);
    check({tag, "_id"}, win_id, 0);
    check({tag, "_valid"}, win_valid, 0);
    check({tag, "_done"}, win_done, 0);
    check({tag, "_clr"}, win_clr, 0);
    check({tag, "_fd"}, frame_done, 0);
  endtask

  // Monitor: pops expected taps and checks sequencing, timing and throttling.
  always @(negedge clk) begin
    if (!rst_n) begin
      windows_done = 0; tap_run = 0; dropped = 0; recovered = 0;
      prev_valid = 0; prev_done = 0; prev_clr = 0; prev_fd = 0; prev_ready = 0;
    end else begin
      hot = int'(win_valid) + int'(win_done) + int'(win_clr);
      if (hot != 0) check("exclusive", hot, 1);
      if (win_valid) begin
        if (!prev_valid) begin
          if (windows_done == 0) check("first_latency", 32'(($time - 5 - t_row2) / 10), 2);
          else                   check("window_gap", 32'(($time - last_rise) / 10), 27);
          last_rise = $time;
        end
        tap_run++;
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("tap_id", win_id, e.id);
          check("tap_pix", win_pixel, e.pix);
        end
        if (windows_done == 19 && win_id == 5'd0)  check("int_id0", win_pixel, 16'h0001);
        if (windows_done == 19 && win_id == 5'd12) check("int_id12", win_pixel, 16'h0023);
        if (windows_done == 19 && win_id == 5'd24) check("int_id24", win_pixel, 16'h0045);
        if (windows_done == 0 && win_id == 5'd0)   check("corner_id0", win_pixel, 16'h0000);
        if (windows_done == 0 && win_id == 5'd12)  check("corner_id12", win_pixel, 16'h0000);
        if (windows_done == 0 && win_id == 5'd24)  check("corner_id24", win_pixel, 16'h0022);
`ifdef GAUSS_FEED_REPLICATE_EN
        if (windows_done == 0 && win_id == 5'd4)   check("corner_id4", win_pixel, 16'h0002);
        if (windows_done == 47 && win_id == 5'd24) check("last_id24", win_pixel, 16'h0057);
`else
        if (windows_done == 0 && win_id == 5'd4)   check("corner_id4", win_pixel, 16'h0000);
        if (windows_done == 47 && win_id == 5'd24) check("last_id24", win_pixel, 16'h0000);
`endif
      end
      if (win_done) begin
        check("tap_run", tap_run, 25);
        tap_run = 0;
      end
      if (win_clr) begin
        check("clr_after_done", prev_done, 1);
        windows_done++;
      end
      if (prev_ready && !in_ready && !dropped) begin
        dropped = 1;
        check("drop_after_row3", accepted, 4 * W);
      end
      if (!prev_ready && in_ready && dropped && !recovered) begin
        recovered = 1;
        check("recover_window", windows_done, W);
        check("recover_on_clr", win_clr, 1);
      end
      if (prev_fd) check("ready_after_fd", in_ready, 1);
      if (frame_done) begin
        check("fd_after_clr", prev_clr, 1);
        check("fd_windows", windows_done, W * H);
        check("fd_ready_low", in_ready, 0);
        frames_seen++;
        windows_done = 0;
        dropped = 0;
        recovered = 0;
      end
      prev_valid = win_valid;
      prev_done  = win_done;
      prev_clr   = win_clr;
      prev_fd    = frame_done;
      prev_ready = in_ready;
    end
  end

  // Drives one ramp frame; abort_win >= 0 pulses reset during tap 5 of that window.
  task automatic run_frame(input int abort_win, output logic aborted);
    int budget;
    int f0;
    aborted = 1'b0;
    accepted = 0;
    t_row2 = 0;
    f0 = frames_seen;
    for (int cy = 0; cy < H; cy++)
      for (int cx = 0; cx < W; cx++)
        for (int id = 0; id < 25; id++)
          sb.push_back('{id: 5'(id), pix: exp_tap(cx, cy, id)});
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        budget = 0;
        forever begin
          @(negedge clk);
          in_valid = 1'b1;
          in_pixel = 16'(16 * r + c);
          if (abort_win >= 0 && windows_done == abort_win && win_valid && win_id == 5'd5) begin
            #2 rst_n = 1'b0;
            #1 check_outputs_zero("rst_mid");
            in_valid = 1'b0;
            sb.delete();
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            aborted = 1'b1;
            return;
          end
          if (in_ready) break;
          budget++;
          if (budget > 2000) begin
            check("ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
          end
        end
        @(posedge clk);
        accepted++;
        if (r == 2 && c == W - 1) t_row2 = $time;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (abort_win >= 0) check("abort_missed", 0, 1);
    budget = 0;
    while (frames_seen == f0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check("frame_done_seen", frames_seen - f0, 1);
    check("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    logic ab;
    #12 check_outputs_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(-1, ab);
    run_frame(W + 4, ab);
    check("abort_taken", ab, 1);
    run_frame(-1, ab);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
